// File: rtl/div_pkg.sv
// Shared definitions for the multicycle signed divider: FSM encoding,
// loop length and small two's-complement magnitude helpers.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 5;

    // Count value of the final shift-subtract step
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

    // Magnitude of a 32-bit two's-complement word; 0x80000000 maps to 2^31
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Conditional 32-bit two's-complement negation
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
// The remainder is widened by one bit so the trial subtraction's sign
// bit tells whether the shifted remainder covers the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_shifted;
    logic [WIDTH:0] trial;

    // Shift {rem, quo} left, try the subtraction, restore on borrow
    always_comb begin
        rem_shifted = {rem, quo[WIDTH-1]};
        trial       = rem_shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider for DIV: quotient to LO, remainder to HI.
// Operates on magnitudes for 32 steps, then fixes signs in one cycle.
// Divide-by-zero is answered straight from IDLE without touching HI/LO.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   count_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic [WIDTH-1:0]   dvsr_reg;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic               sign_q_reg;
    logic               sign_r_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               done_reg;
    logic               div_zero_reg;

    logic               busy_c;
    logic               load_c;
    logic               zero_c;
    logic               step_c;
    logic               finish_c;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (dvsr_reg),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic: zero divisor never leaves IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && (divisor != '0)) state_next = RUN;
            RUN:     if (count_reg == LAST_STEP)   state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded controls; start is only honoured in IDLE
    always_comb begin
        busy_c   = (state_reg != IDLE);
        load_c   = (state_reg == IDLE) && start && (divisor != '0);
        zero_c   = (state_reg == IDLE) && start && (divisor == '0);
        step_c   = (state_reg == RUN);
        finish_c = (state_reg == FIX);
    end

    // Datapath: operand capture, iteration, sign fix-up and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg    <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            dvsr_reg     <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg     <= finish_c | zero_c;
            div_zero_reg <= zero_c;
            if (load_c) begin
                sign_q_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                sign_r_reg <= dividend[WIDTH-1];
                quo_reg    <= mag32(dividend);
                dvsr_reg   <= mag32(divisor);
                rem_reg    <= '0;
                count_reg  <= '0;
            end
            if (step_c) begin
                rem_reg   <= rem_step;
                quo_reg   <= quo_step;
                count_reg <= count_reg + CNT_W'(1);
            end
            if (finish_c) begin
                lo_reg <= neg_if(sign_q_reg, quo_reg);
                hi_reg <= neg_if(sign_r_reg, rem_reg);
            end
        end
    end

    assign busy     = busy_c;
    assign done     = done_reg;
    assign div_zero = div_zero_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: behavioural timing/result model,
// per-cycle compare process, directed literal cases and random ops.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: signed truncating division from plain unsigned arithmetic
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub, q, r, lo_e, hi_e;
        ua   = a[31] ? -a : a;
        ub   = b[31] ? -b : b;
        q    = ua / ub;
        r    = ua % ub;
        lo_e = (a[31] ^ b[31]) ? -q : q;
        hi_e = a[31] ? -r : r;
        return {hi_e, lo_e};
    endfunction

    // Behavioural model: an accepted op occupies 33 cycles, then publishes
    int          m_left;
    logic        m_done, m_dz;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    if (divisor == 32'd0) begin
                        m_done <= 1'b1;
                        m_dz   <= 1'b1;
                    end else begin
                        m_left <= 33;
                        {p_hi, p_lo} <= ref_div(dividend, divisor);
                    end
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("cyc.busy", {31'b0, busy}, {31'b0, (m_left != 0)});
        chk("cyc.done", {31'b0, done}, {31'b0, m_done});
        chk("cyc.div_zero", {31'b0, div_zero}, {31'b0, m_dz});
        chk("cyc.hi", hi, m_hi);
        chk("cyc.lo", lo, m_lo);
    end

    // Present one start pulse; returns just after the accepting edge
    task automatic go(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1 start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycles (negedges) after the accepting edge until done; 40 if never
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 40;
        busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic op(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int cyc, bc;
        go(a, b);
        wait_done(cyc, bc);
        $display("op %s: %h / %h -> lo=%h hi=%h after %0d cycles", name, a, b, lo, hi, cyc);
        chk({name, ".latency"}, 32'(cyc), 32'd34);
        chk({name, ".busy_cycles"}, 32'(bc), 32'd33);
        chk({name, ".lo"}, lo, exp_lo);
        chk({name, ".hi"}, hi, exp_hi);
    endtask

    initial begin
        int cyc, bc, extra;
        bit seen;
        logic [31:0] a, b;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset.busy", {31'b0, busy}, 32'd0);
        chk("reset.done", {31'b0, done}, 32'd0);
        chk("reset.hi", hi, 32'd0);
        chk("reset.lo", lo, 32'd0);

        op("basic", 32'd100, 32'd7, 32'd14, 32'd2);
        op("neg_dividend", -32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
        op("neg_divisor", 32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2);
        op("neg_both", -32'sd100, -32'sd7, 32'd14, 32'hFFFFFFFE);

        // Divide by zero leaves the preloaded HI/LO alone
        op("preload", 32'd68, 32'd7, 32'd9, 32'd5);
        go(32'd123, 32'd0);
        wait_done(cyc, bc);
        $display("op div0: 123 / 0 -> div_zero=%b lo=%h hi=%h after %0d cycles", div_zero, lo, hi, cyc);
        chk("div0.latency", 32'(cyc), 32'd1);
        chk("div0.flag", {31'b0, div_zero}, 32'd1);
        chk("div0.busy_cycles", 32'(bc), 32'd0);
        chk("div0.hi", hi, 32'd5);
        chk("div0.lo", lo, 32'd9);

        op("overflow", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        op("min_by_one", 32'h80000000, 32'd1, 32'h80000000, 32'd0);
        op("zero_dividend", 32'd0, 32'd5, 32'd0, 32'd0);

        // start held high with operands churning, plus a re-pulse mid-run
        @(posedge clk);
        #1 start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk);
        cyc = 40;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1 dividend = $urandom; divisor = $urandom;
            if (i == 18) start = 1'b0;
            if (i == 20) start = 1'b1;
            @(negedge clk);
            if (done) begin
                seen = 1;
                cyc = i + 1;
                start = 1'b0;
            end else begin
                @(posedge clk);
            end
        end
        $display("op held_start: 1000 / 3 -> lo=%h hi=%h after %0d cycles", lo, hi, cyc);
        chk("held.latency", 32'(cyc), 32'd34);
        chk("held.lo", lo, 32'd333);
        chk("held.hi", hi, 32'd1);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("held.extra_done", 32'(extra), 32'd0);

        // Back-to-back: new start raised in the done cycle
        go(32'd200, 32'd9);
        wait_done(cyc, bc);
        chk("b2b_first.lo", lo, 32'd22);
        chk("b2b_first.hi", hi, 32'd2);
        start = 1'b1; dividend = 32'd77; divisor = -32'sd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc, bc);
        $display("op b2b: 77 / -5 -> lo=%h hi=%h after %0d cycles", lo, hi, cyc);
        chk("b2b.latency", 32'(cyc), 32'd34);
        chk("b2b.lo", lo, 32'hFFFFFFF1);
        chk("b2b.hi", hi, 32'd2);

        // Asynchronous reset in the middle of RUN
        go(32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        $display("reset mid-run: busy=%b lo=%h hi=%h", busy, lo, hi);
        chk("midreset.busy", {31'b0, busy}, 32'd0);
        chk("midreset.hi", hi, 32'd0);
        chk("midreset.lo", lo, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("midreset.no_done", 32'(extra), 32'd0);
        op("after_reset", 32'd9, 32'd2, 32'd4, 32'd1);

        // Randomized operations with idle gaps
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFFFFFF;
                3:       b = $urandom_range(1, 20);
                4:       b = 32'h80000000;
                default: b = $urandom;
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clk);
            go(a, b);
            wait_done(cyc, bc);
            $display("op rand%0d: %h / %h -> lo=%h hi=%h dz=%b after %0d cycles",
                     n, a, b, lo, hi, div_zero, cyc);
            chk("rand.latency", 32'(cyc), (b == 32'd0) ? 32'd1 : 32'd34);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
